sprite_priority_finder: RTL and testbench
=========================================

# sprite_priority_finder

Parametrised sprite lookup engine for the video pipeline. It keeps a per-sprite table of anchor position, layer and enable, written through a command port. For each pixel query (H, V) it returns up to NUM_OUT sprite IDs covering that pixel, highest layer first. It also answers sprite-pair bounding-box collision queries. It sits between the game-logic command source and the sprite memory controller, which consumes result_ids.

## Interface
- NUM_SPRITES, 32: number of sprite table entries; minimum 2.
- ID_W, 6: sprite ID width; 2^ID_W must be greater than NUM_SPRITES, so the all-ones ID is free as NO_SPRITE.
- COORD_W, 10: width of H/V and anchor coordinates.
- SPRITE_SIZE, 16: sprite edge length in pixels (square sprites).
- LAYER_W, 4: layer width; a larger value means nearer the viewer.
- NUM_OUT, 4: number of result slots.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  0 SET_POS, 1 SET_LAYER, 2 SET_EN, 3 COLLIDE
- cmd_id  in  ID_W  target sprite (sprite A for COLLIDE)
- cmd_id_b  in  ID_W  sprite B for COLLIDE
- cmd_x, cmd_y  in  COORD_W  anchor for SET_POS
- cmd_layer  in  LAYER_W  layer for SET_LAYER
- cmd_en  in  1  enable value for SET_EN
- query_valid  in  1  pixel query request
- query_ready  out  1  query accepted when high with query_valid
- query_h, query_v  in  COORD_W  pixel position
- result_valid  out  1  one-cycle pulse; result fields valid
- result_count  out  $clog2(NUM_OUT+1)  number of non-empty slots
- result_ids  out  NUM_OUT*ID_W  slot 0 in the LSBs; slot 0 is the highest priority
- coll_valid  out  1  one-cycle pulse; coll_hit valid
- coll_hit  out  1  1 when sprites A and B overlap

## Operation
- Table reset values: anchors 0, layers 0, enables 0.
- FSM states: IDLE, SCAN, DONE, COLL.
- IDLE:
  - cmd_ready = 1.
  - query_ready = !cmd_valid. A command wins over a simultaneous query; the query is held off.
  - SET_POS, SET_LAYER and SET_EN write the table in the cycle they are accepted and the FSM stays in IDLE.
  - COLLIDE moves the FSM to COLL.
  - An accepted query latches H/V, clears all slots to NO_SPRITE and moves the FSM to SCAN with idx = 0.
- SCAN:
  - Sprite idx hits when it is enabled and anchor_x ≤ H ≤ anchor_x + SPRITE_SIZE − 1, and likewise for V.
  - The bound is computed in COORD_W+1 bits, so it never wraps. An anchor at 1020 covers 1020..1035; pixel H = 3 does not hit it.
  - A hit is insertion-sorted into the slot list by layer, descending. Ties go to the lower ID, which is already placed because the scan order is ascending.
  - When the list is full, a hit whose layer is not strictly greater than slot NUM_OUT−1 is dropped.
  - The FSM moves to DONE after idx = NUM_SPRITES−1.
- DONE: result_valid = 1 for one cycle, then the FSM returns to IDLE.
- COLL: the FSM returns to IDLE with coll_valid = 1.
  - coll_hit = 1 when both sprites are enabled, and |xa−xb| < SPRITE_SIZE, and |ya−yb| < SPRITE_SIZE.
  - A == B with the sprite enabled gives coll_hit = 1.
- An ID ≥ NUM_SPRITES is handled as follows:
  - Write commands with such an ID are accepted and ignored.
  - COLLIDE with such an ID gives coll_hit = 0.
- cmd_ready and query_ready are 0 outside IDLE.
- Table writes cannot occur during SCAN, so a scan always sees a consistent table.

## Timing
- Query latency: accept at cycle t gives result_valid at cycle t + NUM_SPRITES + 1. The next query can be accepted at t + NUM_SPRITES + 2.
- Collision latency: accept at t gives coll_valid at t+1.
- Write commands take effect for any query accepted in a later cycle.
- Output reset values:
  - cmd_ready = 1, query_ready = 1.
  - result_valid = 0, coll_valid = 0, coll_hit = 0.
  - result_count = 0, result_ids all ones (NO_SPRITE in every slot).
- result_ids, result_count and coll_hit hold their values until the next DONE or COLL.
- Reset asserted mid-SCAN or mid-COLL aborts the operation. No result pulse is produced and the table is cleared.

## Configuration
- SPRITE_COLLISION_EN defined: COLLIDE behaves as specified above.
- SPRITE_COLLISION_EN undefined:
  - The overlap logic is not built.
  - COLLIDE is still accepted and coll_valid still pulses at t+1.
  - coll_hit is constant 0.

## Structure
- Package sprite_pkg:
  - cmd_op encodings (OP_SET_POS, OP_SET_LAYER, OP_SET_EN, OP_COLLIDE).
  - FSM state enum.
  - NO_SPRITE function of ID_W, returning all ones.
- Sub-module sprite_box_hit: combinational point-in-box compare with an overflow-safe COORD_W+1 upper bound. It is instantiated once for SCAN; the collision check reuses the same width rule.

## Test plan
- Reset, then query (100,100) → result_valid after 33 cycles, result_count 0, all slots 0x3F.
- Sprite 5 at (100,100), layer 2, enabled; sprite 9 at (108,104), layer 7, enabled; query (110,110) → ids [9,5,3F,3F], count 2.
- Six enabled sprites at the same anchor with layers 1,1,3,3,5,0 (ids 0–5) → ids [4,2,3,0], count 4; sprite 1 drops on its tie with sprite 0, sprite 5 has the lowest layer.
- Sprite 0 at (1020,0), enabled; query (1023,5) → hit; query (3,5) → no hit (no wrap).
- COLLIDE: sprites at (0,0) and (15,0) → coll_hit 1; at (16,0) → 0; one sprite disabled → 0; cmd_id 40 → 0; coll_valid exactly 1 cycle after accept.
- Concurrency and reset:
  - cmd_valid and query_valid asserted together in IDLE → the command is accepted and query_ready stays 0 that cycle.
  - Reset asserted at scan cycle 10 → no result_valid and all outputs at reset values.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared encodings, FSM states and helpers for the sprite priority finder.
package sprite_pkg;

  localparam logic [1:0] OP_SET_POS   = 2'd0;
  localparam logic [1:0] OP_SET_LAYER = 2'd1;
  localparam logic [1:0] OP_SET_EN    = 2'd2;
  localparam logic [1:0] OP_COLLIDE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE,
    ST_COLL
  } state_e;

  localparam int unsigned MAX_ID_W = 16;

  // All-ones ID of the given width, reserved as the empty-slot marker.
  function automatic logic [MAX_ID_W-1:0] no_sprite(input int unsigned id_w);
    logic [31:0] ones;
    ones = (32'd1 << id_w) - 32'd1;
    return MAX_ID_W'(ones);
  endfunction

endpackage

// File: rtl/sprite_box_hit.sv
// Point-in-square test; the upper bound is formed one bit wider so it never wraps.
module sprite_box_hit
  import sprite_pkg::*;
#(
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned SPRITE_SIZE = 16
) (
  input  logic [COORD_W-1:0] anchor_x,
  input  logic [COORD_W-1:0] anchor_y,
  input  logic [COORD_W-1:0] pt_x,
  input  logic [COORD_W-1:0] pt_y,
  output logic               hit_c
);

  localparam int unsigned EXT_W = COORD_W + 1;

  logic [EXT_W-1:0] x_hi;
  logic [EXT_W-1:0] y_hi;

  assign x_hi  = EXT_W'(anchor_x) + EXT_W'(SPRITE_SIZE - 1);
  assign y_hi  = EXT_W'(anchor_y) + EXT_W'(SPRITE_SIZE - 1);
  assign hit_c = (pt_x >= anchor_x) && (EXT_W'(pt_x) <= x_hi) &&
                 (pt_y >= anchor_y) && (EXT_W'(pt_y) <= y_hi);

endmodule

// File: rtl/sprite_priority_finder.sv
// Sprite table with per-pixel priority scan and pair collision query.
// Optional feature macro: SPRITE_COLLISION_EN builds the overlap logic; otherwise coll_hit is 0.
module sprite_priority_finder
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 32,
  parameter int unsigned ID_W        = 6,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned SPRITE_SIZE = 16,
  parameter int unsigned LAYER_W     = 4,
  parameter int unsigned NUM_OUT     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [ID_W-1:0]                  cmd_id,
  input  logic [ID_W-1:0]                  cmd_id_b,
  input  logic [COORD_W-1:0]               cmd_x,
  input  logic [COORD_W-1:0]               cmd_y,
  input  logic [LAYER_W-1:0]               cmd_layer,
  input  logic                             cmd_en,
  input  logic                             query_valid,
  output logic                             query_ready,
  input  logic [COORD_W-1:0]               query_h,
  input  logic [COORD_W-1:0]               query_v,
  output logic                             result_valid,
  output logic [$clog2(NUM_OUT+1)-1:0]     result_count,
  output logic [NUM_OUT*ID_W-1:0]          result_ids,
  output logic                             coll_valid,
  output logic                             coll_hit
);

  localparam int unsigned IDX_W = $clog2(NUM_SPRITES);
  localparam int unsigned CNT_W = $clog2(NUM_OUT + 1);
  localparam logic [ID_W-1:0]  NO_ID    = ID_W'(no_sprite(ID_W));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

  state_e state_q, state_d;

  logic [COORD_W-1:0] anchor_x_q [NUM_SPRITES];
  logic [COORD_W-1:0] anchor_x_d [NUM_SPRITES];
  logic [COORD_W-1:0] anchor_y_q [NUM_SPRITES];
  logic [COORD_W-1:0] anchor_y_d [NUM_SPRITES];
  logic [LAYER_W-1:0] layer_q    [NUM_SPRITES];
  logic [LAYER_W-1:0] layer_d    [NUM_SPRITES];
  logic               en_q       [NUM_SPRITES];
  logic               en_d       [NUM_SPRITES];

  logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
  logic [COORD_W-1:0] qh_q, qh_d, qv_q, qv_d;

  logic [ID_W-1:0]    slot_id_q    [NUM_OUT];
  logic [ID_W-1:0]    slot_id_d    [NUM_OUT];
  logic [LAYER_W-1:0] slot_layer_q [NUM_OUT];
  logic [LAYER_W-1:0] slot_layer_d [NUM_OUT];
  logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;

  logic                    result_valid_q, result_valid_d;
  logic [CNT_W-1:0]        result_count_q, result_count_d;
  logic [NUM_OUT*ID_W-1:0] result_ids_q, result_ids_d;
  logic                    coll_valid_q, coll_valid_d;
  logic                    coll_hit_q, coll_hit_d;

  logic               id_a_ok;
  logic [IDX_W-1:0]   id_a;
  logic               box_hit_c;
  logic               scan_hit_c;
  logic [LAYER_W-1:0] hit_layer_c;
  logic [CNT_W-1:0]   ins_pos_c;
  logic               coll_hit_c;

  assign id_a_ok = cmd_id < ID_W'(NUM_SPRITES);
  assign id_a    = IDX_W'(cmd_id);

  sprite_box_hit #(
    .COORD_W     (COORD_W),
    .SPRITE_SIZE (SPRITE_SIZE)
  ) u_box_hit (
    .anchor_x (anchor_x_q[scan_idx_q]),
    .anchor_y (anchor_y_q[scan_idx_q]),
    .pt_x     (qh_q),
    .pt_y     (qv_q),
    .hit_c    (box_hit_c)
  );

  assign scan_hit_c  = en_q[scan_idx_q] && box_hit_c;
  assign hit_layer_c = layer_q[scan_idx_q];

  // Slots are sorted, so entries at or above the hit's layer form a prefix.
  always_comb begin
    ins_pos_c = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (CNT_W'(i) < slot_cnt_q && slot_layer_q[i] >= hit_layer_c) begin
        ins_pos_c = CNT_W'(i + 1);
      end
    end
  end

`ifdef SPRITE_COLLISION_EN
  localparam int unsigned EXT_W = COORD_W + 1;

  logic               id_b_ok;
  logic [IDX_W-1:0]   id_b;
  logic [COORD_W-1:0] xa, xb, ya, yb, dx, dy;

  assign id_b_ok = cmd_id_b < ID_W'(NUM_SPRITES);
  assign id_b    = IDX_W'(cmd_id_b);

  always_comb begin
    xa = anchor_x_q[id_a];
    xb = anchor_x_q[id_b];
    ya = anchor_y_q[id_a];
    yb = anchor_y_q[id_b];
    dx = (xa >= xb) ? (xa - xb) : (xb - xa);
    dy = (ya >= yb) ? (ya - yb) : (yb - ya);
    coll_hit_c = id_a_ok && id_b_ok && en_q[id_a] && en_q[id_b] &&
                 (EXT_W'(dx) < EXT_W'(SPRITE_SIZE)) &&
                 (EXT_W'(dy) < EXT_W'(SPRITE_SIZE));
  end
`else
  logic unused_coll;
  assign unused_coll = ^cmd_id_b;
  assign coll_hit_c  = 1'b0;
`endif

  // Next-state, table writes, slot insertion and output staging.
  always_comb begin
    state_d        = state_q;
    anchor_x_d     = anchor_x_q;
    anchor_y_d     = anchor_y_q;
    layer_d        = layer_q;
    en_d           = en_q;
    scan_idx_d     = scan_idx_q;
    qh_d           = qh_q;
    qv_d           = qv_q;
    slot_id_d      = slot_id_q;
    slot_layer_d   = slot_layer_q;
    slot_cnt_d     = slot_cnt_q;
    result_valid_d = 1'b0;
    result_count_d = result_count_q;
    result_ids_d   = result_ids_q;
    coll_valid_d   = 1'b0;
    coll_hit_d     = coll_hit_q;
    cmd_ready      = 1'b0;
    query_ready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready   = 1'b1;
        query_ready = !cmd_valid;
        if (cmd_valid) begin
          case (cmd_op)
            OP_SET_POS: begin
              if (id_a_ok) begin
                anchor_x_d[id_a] = cmd_x;
                anchor_y_d[id_a] = cmd_y;
              end
            end
            OP_SET_LAYER: begin
              if (id_a_ok) layer_d[id_a] = cmd_layer;
            end
            OP_SET_EN: begin
              if (id_a_ok) en_d[id_a] = cmd_en;
            end
            default: begin
              state_d      = ST_COLL;
              coll_valid_d = 1'b1;
              coll_hit_d   = coll_hit_c;
            end
          endcase
        end else if (query_valid) begin
          state_d    = ST_SCAN;
          scan_idx_d = '0;
          qh_d       = query_h;
          qv_d       = query_v;
          slot_cnt_d = '0;
          for (int i = 0; i < NUM_OUT; i++) begin
            slot_id_d[i]    = NO_ID;
            slot_layer_d[i] = '0;
          end
        end
      end

      ST_SCAN: begin
        if (scan_hit_c && ins_pos_c < CNT_W'(NUM_OUT)) begin
          for (int i = 1; i < NUM_OUT; i++) begin
            if (CNT_W'(i) > ins_pos_c) begin
              slot_id_d[i]    = slot_id_q[i-1];
              slot_layer_d[i] = slot_layer_q[i-1];
            end
          end
          for (int i = 0; i < NUM_OUT; i++) begin
            if (CNT_W'(i) == ins_pos_c) begin
              slot_id_d[i]    = ID_W'(scan_idx_q);
              slot_layer_d[i] = hit_layer_c;
            end
          end
          if (slot_cnt_q < CNT_W'(NUM_OUT)) slot_cnt_d = slot_cnt_q + CNT_W'(1);
        end
        if (scan_idx_q == LAST_IDX) begin
          state_d        = ST_DONE;
          result_valid_d = 1'b1;
          result_count_d = slot_cnt_d;
          for (int i = 0; i < NUM_OUT; i++) begin
            result_ids_d[i*ID_W +: ID_W] = slot_id_d[i];
          end
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;
      ST_COLL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      scan_idx_q     <= '0;
      qh_q           <= '0;
      qv_q           <= '0;
      slot_cnt_q     <= '0;
      result_valid_q <= 1'b0;
      result_count_q <= '0;
      result_ids_q   <= {NUM_OUT{NO_ID}};
      coll_valid_q   <= 1'b0;
      coll_hit_q     <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        anchor_x_q[i] <= '0;
        anchor_y_q[i] <= '0;
        layer_q[i]    <= '0;
        en_q[i]       <= 1'b0;
      end
      for (int i = 0; i < NUM_OUT; i++) begin
        slot_id_q[i]    <= NO_ID;
        slot_layer_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      scan_idx_q     <= scan_idx_d;
      qh_q           <= qh_d;
      qv_q           <= qv_d;
      slot_cnt_q     <= slot_cnt_d;
      result_valid_q <= result_valid_d;
      result_count_q <= result_count_d;
      result_ids_q   <= result_ids_d;
      coll_valid_q   <= coll_valid_d;
      coll_hit_q     <= coll_hit_d;
      anchor_x_q     <= anchor_x_d;
      anchor_y_q     <= anchor_y_d;
      layer_q        <= layer_d;
      en_q           <= en_d;
      slot_id_q      <= slot_id_d;
      slot_layer_q   <= slot_layer_d;
    end
  end

  assign result_valid = result_valid_q;
  assign result_count = result_count_q;
  assign result_ids   = result_ids_q;
  assign coll_valid   = coll_valid_q;
  assign coll_hit     = coll_hit_q;

endmodule

// File: tb/tb_sprite_priority_finder.sv
// Directed, table-driven bench for sprite_priority_finder.
module tb_sprite_priority_finder;

  localparam int unsigned NS  = 32;
  localparam int unsigned IDW = 6;
  localparam int unsigned CW  = 10;
  localparam int unsigned LW  = 4;
  localparam int unsigned NO  = 4;
  localparam int unsigned RCW = 3;
`ifdef SPRITE_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif
  localparam logic [1:0] OP_POS = 2'd0, OP_LAY = 2'd1, OP_EN = 2'd2, OP_COL = 2'd3;
  localparam logic [23:0] EMPTY = 24'hFFFFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [IDW-1:0]    cmd_id = '0;
  logic [IDW-1:0]    cmd_id_b = '0;
  logic [CW-1:0]     cmd_x = '0;
  logic [CW-1:0]     cmd_y = '0;
  logic [LW-1:0]     cmd_layer = '0;
  logic              cmd_en = 1'b0;
  logic              query_valid = 1'b0;
  logic              query_ready;
  logic [CW-1:0]     query_h = '0;
  logic [CW-1:0]     query_v = '0;
  logic              result_valid;
  logic [RCW-1:0]    result_count;
  logic [NO*IDW-1:0] result_ids;
  logic              coll_valid;
  logic              coll_hit;

  int total = 0;
  int bad   = 0;

  sprite_priority_finder #(
    .NUM_SPRITES (NS),
    .ID_W        (IDW),
    .COORD_W     (CW),
    .SPRITE_SIZE (16),
    .LAYER_W     (LW),
    .NUM_OUT     (NO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_id       (cmd_id),
    .cmd_id_b     (cmd_id_b),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_layer    (cmd_layer),
    .cmd_en       (cmd_en),
    .query_valid  (query_valid),
    .query_ready  (query_ready),
    .query_h      (query_h),
    .query_v      (query_v),
    .result_valid (result_valid),
    .result_count (result_count),
    .result_ids   (result_ids),
    .coll_valid   (coll_valid),
    .coll_hit     (coll_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0]  h;
    logic [CW-1:0]  v;
    logic [RCW-1:0] cnt;
    logic [23:0]    ids;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input int id, input int x, input int y,
                        input int layer, input bit en);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_id    = IDW'(id);
    cmd_x     = CW'(x);
    cmd_y     = CW'(y);
    cmd_layer = LW'(layer);
    cmd_en    = en;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic place(input int id, input int x, input int y, input int layer);
    do_cmd(OP_POS, id, x, y, 0, 1'b0);
    do_cmd(OP_LAY, id, 0, 0, layer, 1'b0);
    do_cmd(OP_EN, id, 0, 0, 0, 1'b1);
  endtask

  task automatic do_query(input int h, input int v, output logic [23:0] ids,
                          output logic [RCW-1:0] cnt, output int lat);
    query_valid = 1'b1;
    query_h     = CW'(h);
    query_v     = CW'(v);
    @(posedge clk); #1;
    query_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    ids = result_ids;
    cnt = result_count;
    @(posedge clk); #1;
    check("result_valid_pulse", 32'(result_valid), 32'd0);
  endtask

  task automatic run_query(input string name, input int h, input int v,
                           input logic [RCW-1:0] exp_cnt, input logic [23:0] exp_ids);
    logic [23:0]    ids;
    logic [RCW-1:0] cnt;
    int             lat;
    do_query(h, v, ids, cnt, lat);
    check({name, "_lat"}, 32'(lat), 32'(NS + 1));
    check({name, "_cnt"}, 32'(cnt), 32'(exp_cnt));
    check({name, "_ids"}, 32'(ids), 32'(exp_ids));
  endtask

  task automatic collide(input string name, input int ida, input int idb, input bit exp);
    cmd_valid = 1'b1;
    cmd_op    = OP_COL;
    cmd_id    = IDW'(ida);
    cmd_id_b  = IDW'(idb);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check({name, "_cvalid"}, 32'(coll_valid), 32'd1);
    check({name, "_hit"}, 32'(coll_hit), 32'(exp & COLL_EN));
    check({name, "_busy"}, 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check({name, "_cvalid_end"}, 32'(coll_valid), 32'd0);
  endtask

  initial begin
    bit seen;

    vecs[0] = '{h: 110, v: 110, cnt: 2, ids: {6'h3F, 6'h3F, 6'd5, 6'd9}};
    vecs[1] = '{h: 100, v: 100, cnt: 1, ids: {6'h3F, 6'h3F, 6'h3F, 6'd5}};
    vecs[2] = '{h: 115, v: 100, cnt: 1, ids: {6'h3F, 6'h3F, 6'h3F, 6'd5}};
    vecs[3] = '{h: 116, v: 104, cnt: 1, ids: {6'h3F, 6'h3F, 6'h3F, 6'd9}};
    vecs[4] = '{h: 99,  v: 100, cnt: 0, ids: EMPTY};
    vecs[5] = '{h: 123, v: 119, cnt: 1, ids: {6'h3F, 6'h3F, 6'h3F, 6'd9}};
    vecs[6] = '{h: 124, v: 119, cnt: 0, ids: EMPTY};
    vecs[7] = '{h: 108, v: 115, cnt: 2, ids: {6'h3F, 6'h3F, 6'd5, 6'd9}};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_query_ready", 32'(query_ready), 32'd1);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_coll_valid", 32'(coll_valid), 32'd0);
    check("rst_coll_hit", 32'(coll_hit), 32'd0);
    check("rst_count", 32'(result_count), 32'd0);
    check("rst_ids", 32'(result_ids), 32'(EMPTY));
    rst = 1'b1;
    @(posedge clk); #1;

    run_query("empty", 100, 100, 3'd0, EMPTY);

    place(5, 100, 100, 2);
    place(9, 108, 104, 7);
    for (int i = 0; i < 8; i++) begin
      run_query($sformatf("vec%0d", i), int'(vecs[i].h), int'(vecs[i].v), vecs[i].cnt, vecs[i].ids);
    end

    // Six sprites stacked: layer sort, tie order and full-list drop.
    place(0, 300, 300, 1);
    place(1, 300, 300, 1);
    place(2, 300, 300, 3);
    place(3, 300, 300, 3);
    place(4, 300, 300, 5);
    place(5, 300, 300, 0);
    run_query("stack", 305, 305, 3'd4, {6'd0, 6'd3, 6'd2, 6'd4});

    // Anchor near the right edge must not wrap to low H.
    do_cmd(OP_POS, 0, 1020, 0, 0, 1'b0);
    run_query("edge_hit", 1023, 5, 3'd1, {6'h3F, 6'h3F, 6'h3F, 6'd0});
    run_query("edge_nowrap", 3, 5, 3'd0, EMPTY);
    run_query("stack2", 305, 305, 3'd4, {6'd1, 6'd3, 6'd2, 6'd4});

    // Out-of-range ID aliasing onto sprite 8 must be ignored.
    place(8, 500, 500, 0);
    do_cmd(OP_POS, 40, 600, 600, 0, 1'b0);
    do_cmd(OP_EN, 40, 0, 0, 0, 1'b0);
    run_query("oob_write", 505, 505, 3'd1, {6'h3F, 6'h3F, 6'h3F, 6'd8});

    // Collision queries.
    place(10, 0, 0, 0);
    place(11, 15, 0, 0);
    collide("coll_15", 10, 11, 1'b1);
    collide("coll_self", 10, 10, 1'b1);
    do_cmd(OP_POS, 11, 16, 0, 0, 1'b0);
    collide("coll_16", 10, 11, 1'b0);
    do_cmd(OP_POS, 11, 0, 15, 0, 1'b0);
    collide("coll_y15", 11, 10, 1'b1);
    do_cmd(OP_EN, 11, 0, 0, 0, 1'b0);
    collide("coll_dis", 10, 11, 1'b0);
    collide("coll_oob", 40, 10, 1'b0);
    check("result_hold", 32'(result_ids), 32'({6'h3F, 6'h3F, 6'h3F, 6'd8}));

    // Command wins over a simultaneous query.
    cmd_valid   = 1'b1;
    cmd_op      = OP_LAY;
    cmd_id      = IDW'(20);
    cmd_layer   = LW'(1);
    query_valid = 1'b1;
    query_h     = CW'(505);
    query_v     = CW'(505);
    #1;
    check("conc_qready", 32'(query_ready), 32'd0);
    check("conc_cready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
    query_valid = 1'b0;
    check("conc_still_idle", 32'(cmd_ready), 32'd1);

    // Reset in the middle of a scan.
    query_valid = 1'b1;
    query_h     = CW'(505);
    query_v     = CW'(505);
    @(posedge clk); #1;
    query_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_cready", 32'(cmd_ready), 32'd1);
    check("mid_rst_qready", 32'(query_ready), 32'd1);
    check("mid_rst_rvalid", 32'(result_valid), 32'd0);
    check("mid_rst_chit", 32'(coll_hit), 32'd0);
    check("mid_rst_count", 32'(result_count), 32'd0);
    check("mid_rst_ids", 32'(result_ids), 32'(EMPTY));
    @(posedge clk); #1;
    rst  = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (result_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    run_query("table_cleared", 505, 505, 3'd0, EMPTY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
